// File: rtl/mult_pkg.sv
// mult_pkg: shared op and state encodings for the iterative multiplier.
package mult_pkg;
    typedef enum logic [1:0] {OP_MUL, OP_UMULH, OP_SMULH, OP_RSVD} mul_op_e;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} mul_state_e;
endpackage

// File: rtl/mult64_iter.sv
// mult64_iter: radix-2 shift-add multiplier, WIDTH run cycles per MUL/UMULH/SMULH.
module mult64_iter
    import mult_pkg::*;
#(
    parameter int WIDTH = 64,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             flush,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);
    mul_state_e         state, nxt;
    mul_op_e            op_q;
    logic               neg, smul, accept, last;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   mplier, abs_a, abs_b;
    logic [2*WIDTH-1:0] mcand, acc, acc_add, prod;

    // SMULH runs on magnitudes; the sign is reapplied to the full product
    always_comb begin
        smul    = mul_op_e'(op) == OP_SMULH;
        abs_a   = smul && a[WIDTH-1] ? -a : a;
        abs_b   = smul && b[WIDTH-1] ? -b : b;
        accept  = state != S_RUN && start && !flush;
        last    = state == S_RUN && &cnt;
        acc_add = acc + (mplier[0] ? mcand : '0);
        prod    = neg ? -acc_add : acc_add;
        nxt     = flush ? S_IDLE : accept ? S_RUN : last ? S_DONE : state == S_RUN ? S_RUN : S_IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            op_q   <= OP_MUL;
            neg    <= 1'b0;
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else begin
            state <= nxt;
            busy  <= nxt == S_RUN;
            done  <= nxt == S_DONE;
            if (accept) begin
                op_q   <= mul_op_e'(op);
                neg    <= smul && (a[WIDTH-1] ^ b[WIDTH-1]);
                mcand  <= {{WIDTH{1'b0}}, abs_a};
                mplier <= abs_b;
                acc    <= '0;
                cnt    <= '0;
            end else if (state == S_RUN) begin
                acc    <= acc_add;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            result <= '0;
        else if (last && !flush)
            result <= (op_q == OP_UMULH || op_q == OP_SMULH) ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0];
    end
endmodule
